// File: rtl/line_fill_if.sv
// Cache-side, memory-side and fill-side signals of the line fill unit.
// The slave modport is the fill unit itself; master is its environment.
interface line_fill_if #(
  parameter int LINEADDRBITS = 26,
  parameter int WORDBITS     = 32,
  parameter int BEATS        = 16
);
  localparam int BW = $clog2(BEATS);

  logic                    req_valid;
  logic [LINEADDRBITS-1:0] req_addr;
  logic                    req_ready;
  logic                    inv_valid;
  logic [LINEADDRBITS-1:0] inv_addr;
  logic                    mem_req_valid;
  logic [31:0]             mem_req_addr;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [WORDBITS-1:0]     mem_rsp_data;
  logic                    fill_we;
  logic [LINEADDRBITS-1:0] fill_addr;
  logic [BW-1:0]           fill_beat;
  logic [WORDBITS-1:0]     fill_data;
  logic                    fill_done;
  logic                    fill_drop;
  logic                    busy;
  logic [15:0]             coalesce_count;

  modport slave (
    input  req_valid, req_addr, inv_valid, inv_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, mem_req_valid, mem_req_addr,
    output fill_we, fill_addr, fill_beat, fill_data, fill_done, fill_drop,
    output busy, coalesce_count
  );

  modport master (
    output req_valid, req_addr, inv_valid, inv_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, mem_req_valid, mem_req_addr,
    input  fill_we, fill_addr, fill_beat, fill_data, fill_done, fill_drop,
    input  busy, coalesce_count
  );
endinterface

// File: rtl/line_fill_unit.sv
// Queues instruction-cache misses, fetches one 64-byte line at a time as a
// burst, and writes the beats back to the cache, honouring invalidate snoops.
module line_fill_unit #(
  parameter int LINEADDRBITS = 26,
  parameter int WORDBITS     = 32,
  parameter int BEATS        = 16,
  parameter int QDEPTH       = 4
) (
  input logic        clock,
  input logic        reset,
  line_fill_if.slave bus
);
  localparam int BW = $clog2(BEATS);
  localparam int PW = $clog2(QDEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [LINEADDRBITS-1:0] q_addr_reg [QDEPTH];
  logic                    q_vld_reg  [QDEPTH];
  logic [PW-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]             count_reg;

  logic [1:0]              state_reg;
  logic [LINEADDRBITS-1:0] cur_addr_reg;
  logic                    stale_reg;
  logic [BW-1:0]           beat_reg;

  logic                    fill_we_reg, fill_done_reg, fill_drop_reg;
  logic [LINEADDRBITS-1:0] fill_addr_reg;
  logic [BW-1:0]           fill_beat_reg;
  logic [WORDBITS-1:0]     fill_data_reg;
  logic [15:0]             coalesce_reg;

  logic [QDEPTH-1:0] inv_hit, req_hit;
  logic full, empty, in_flight, cur_inv, cur_hit;
  logic accept, coalesce, push, pop, head_ok;

  // A same-cycle snoop masks an entry before the new request is matched, so
  // a request never coalesces into a line that is being invalidated.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_match
    assign inv_hit[gi] = bus.inv_valid && q_vld_reg[gi] && (q_addr_reg[gi] == bus.inv_addr);
    assign req_hit[gi] = q_vld_reg[gi] && !inv_hit[gi] && (q_addr_reg[gi] == bus.req_addr);
  end

  assign full      = (count_reg == (PW+1)'(QDEPTH));
  assign empty     = (count_reg == '0);
  assign in_flight = (state_reg == ST_REQ) || (state_reg == ST_DATA);
  assign cur_inv   = bus.inv_valid && in_flight && (bus.inv_addr == cur_addr_reg);
  assign cur_hit   = in_flight && !stale_reg && !cur_inv && (bus.req_addr == cur_addr_reg);
  assign accept    = bus.req_valid && !full;
  assign coalesce  = accept && ((|req_hit) || cur_hit);
  assign push      = accept && !coalesce;
  assign pop       = (state_reg == ST_IDLE) && !empty;
  assign head_ok   = q_vld_reg[rd_ptr_reg] && !inv_hit[rd_ptr_reg];

  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_vld
    always_ff @(posedge clock) begin
      if (reset) begin
        q_vld_reg[gi] <= 1'b0;
      end else if (push && (wr_ptr_reg == PW'(gi))) begin
        q_vld_reg[gi] <= 1'b1;
      end else if ((pop && (rd_ptr_reg == PW'(gi))) || inv_hit[gi]) begin
        q_vld_reg[gi] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_addr_reg[wr_ptr_reg] <= bus.req_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop);
      count_reg  <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cur_addr_reg  <= '0;
      stale_reg     <= 1'b0;
      beat_reg      <= '0;
      fill_we_reg   <= 1'b0;
      fill_done_reg <= 1'b0;
      fill_drop_reg <= 1'b0;
      fill_addr_reg <= '0;
      fill_beat_reg <= '0;
      fill_data_reg <= '0;
      coalesce_reg  <= '0;
    end else begin
      fill_we_reg   <= 1'b0;
      fill_done_reg <= 1'b0;
      fill_drop_reg <= 1'b0;
      if (coalesce && (coalesce_reg != 16'hFFFF)) begin
        coalesce_reg <= coalesce_reg + 16'd1;
      end
      if (cur_inv) begin
        stale_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          // Invalidated heads are discarded here, one per cycle.
          if (pop && head_ok) begin
            cur_addr_reg <= q_addr_reg[rd_ptr_reg];
            stale_reg    <= 1'b0;
            state_reg    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            beat_reg  <= '0;
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.mem_rsp_valid) begin
            fill_data_reg <= bus.mem_rsp_data;
            fill_beat_reg <= beat_reg;
            fill_addr_reg <= cur_addr_reg;
            fill_we_reg   <= !stale_reg;
            beat_reg      <= beat_reg + BW'(1);
            if (beat_reg == BW'(BEATS-1)) begin
              fill_done_reg <= !stale_reg;
              fill_drop_reg <= stale_reg;
              state_reg     <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = !full;
  assign bus.mem_req_valid  = (state_reg == ST_REQ);
  assign bus.mem_req_addr   = {cur_addr_reg, {(32-LINEADDRBITS){1'b0}}};
  assign bus.fill_we        = fill_we_reg;
  assign bus.fill_addr      = fill_addr_reg;
  assign bus.fill_beat      = fill_beat_reg;
  assign bus.fill_data      = fill_data_reg;
  assign bus.fill_done      = fill_done_reg;
  assign bus.fill_drop      = fill_drop_reg;
  assign bus.busy           = !empty || (state_reg != ST_IDLE);
  assign bus.coalesce_count = coalesce_reg;
endmodule

// File: tb/tb_line_fill_unit.sv
// Directed bench for line_fill_unit: table of single-line fills plus
// hand-written queueing, coalescing, snoop and reset sequences.
module tb_line_fill_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;

  line_fill_if #(.LINEADDRBITS(26), .WORDBITS(32), .BEATS(16)) bus_if ();

  line_fill_unit #(.LINEADDRBITS(26), .WORDBITS(32), .BEATS(16), .QDEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [25:0] addr;
    logic [31:0] base;
    logic [31:0] exp_mem;
  } vec_t;
  vec_t vecs [4];

  int passed = 0;
  int total  = 0;

  logic [25:0] fq_addr [$];
  logic [3:0]  fq_beat [$];
  logic [31:0] fq_data [$];
  logic [31:0] mem_q   [$];
  int done_n = 0;
  int drop_n = 0;
  int f0, m0, d0, p0;

  always @(negedge clock) begin
    if (bus_if.fill_we) begin
      fq_addr.push_back(bus_if.fill_addr);
      fq_beat.push_back(bus_if.fill_beat);
      fq_data.push_back(bus_if.fill_data);
    end
    if (bus_if.fill_done) done_n++;
    if (bus_if.fill_drop) drop_n++;
    if (bus_if.mem_req_valid && bus_if.mem_req_ready) mem_q.push_back(bus_if.mem_req_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic mark;
    f0 = fq_addr.size();
    m0 = mem_q.size();
    d0 = done_n;
    p0 = drop_n;
  endtask

  task automatic idle_inputs;
    bus_if.req_valid     = 1'b0;
    bus_if.req_addr      = '0;
    bus_if.inv_valid     = 1'b0;
    bus_if.inv_addr      = '0;
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_data  = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_req(input logic [25:0] a);
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = a;
    tick();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic do_inv(input logic [25:0] a);
    bus_if.inv_valid = 1'b1;
    bus_if.inv_addr  = a;
    tick();
    bus_if.inv_valid = 1'b0;
  endtask

  task automatic wait_mreq(input string name);
    int n = 0;
    while (!bus_if.mem_req_valid && n < 40) begin
      tick();
      n++;
    end
    check({name, " mem_req_valid"}, bus_if.mem_req_valid, 1);
  endtask

  task automatic grant;
    bus_if.mem_req_ready = 1'b1;
    tick();
    bus_if.mem_req_ready = 1'b0;
  endtask

  task automatic send_beats(input int first, input int n, input logic [31:0] base,
                            input int inv_at, input logic [25:0] inv_a,
                            input int req_at, input logic [25:0] req_a);
    for (int b = first; b < first + n; b++) begin
      bus_if.mem_rsp_valid = 1'b1;
      bus_if.mem_rsp_data  = base + 32'(b * 4);
      bus_if.inv_valid     = (b == inv_at);
      bus_if.inv_addr      = inv_a;
      bus_if.req_valid     = (b == req_at);
      bus_if.req_addr      = req_a;
      tick();
    end
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.inv_valid     = 1'b0;
    bus_if.req_valid     = 1'b0;
  endtask

  task automatic serve(input string name, input logic [31:0] base);
    wait_mreq(name);
    grant();
    send_beats(0, 16, base, -1, '0, -1, '0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " fill_we"}, bus_if.fill_we, 0);
    check({name, " fill_done"}, bus_if.fill_done, 0);
    check({name, " fill_drop"}, bus_if.fill_drop, 0);
    check({name, " mem_req_valid"}, bus_if.mem_req_valid, 0);
    check({name, " fill_beat"}, bus_if.fill_beat, 0);
    check({name, " fill_addr"}, bus_if.fill_addr, 0);
    check({name, " fill_data"}, bus_if.fill_data, 0);
    check({name, " req_ready"}, bus_if.req_ready, 1);
    check({name, " busy"}, bus_if.busy, 0);
  endtask

  initial begin
    vecs[0] = '{addr: 26'h0000123, base: 32'h0000_0000, exp_mem: 32'h0000_48C0};
    vecs[1] = '{addr: 26'h3FFFFFF, base: 32'hDEAD_0000, exp_mem: 32'hFFFF_FFC0};
    vecs[2] = '{addr: 26'h0000001, base: 32'h1234_5670, exp_mem: 32'h0000_0040};
    vecs[3] = '{addr: 26'h2AAAAAA, base: 32'hA5A5_0001, exp_mem: 32'hAAAA_AA80};

    idle_inputs();
    reset = 1'b1;
    tick();
    check_idle_outputs("reset");
    check("reset coalesce_count", bus_if.coalesce_count, 0);
    tick();
    reset = 1'b0;
    tick();

    // single-line fills from the vector table
    for (int v = 0; v < 4; v++) begin
      mark();
      do_req(vecs[v].addr);
      check($sformatf("v%0d mreq at N+1", v), bus_if.mem_req_valid, 0);
      tick();
      check($sformatf("v%0d mreq at N+2", v), bus_if.mem_req_valid, 1);
      check($sformatf("v%0d mem_req_addr", v), bus_if.mem_req_addr, vecs[v].exp_mem);
      grant();
      send_beats(0, 16, vecs[v].base, -1, '0, -1, '0);
      check($sformatf("v%0d last fill_done", v), bus_if.fill_done, 1);
      check($sformatf("v%0d last fill_we", v), bus_if.fill_we, 1);
      check($sformatf("v%0d last fill_beat", v), bus_if.fill_beat, 15);
      tick();
      check($sformatf("v%0d busy after", v), bus_if.busy, 0);
      check($sformatf("v%0d fill count", v), fq_addr.size() - f0, 16);
      for (int i = 0; i < 16 && f0 + i < fq_addr.size(); i++) begin
        check($sformatf("v%0d beat %0d", v, i),
              {fq_addr[f0+i], fq_beat[f0+i], fq_data[f0+i]},
              {vecs[v].addr, 4'(i), vecs[v].base + 32'(i * 4)});
      end
      check($sformatf("v%0d drop count", v), drop_n - p0, 0);
    end

    // fill queue: one line in flight plus four queued makes the FIFO full
    do_reset();
    mark();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("queue ready %0d", i), bus_if.req_ready, 1);
      do_req(26'h100 + 26'(i));
    end
    check("queue full req_ready", bus_if.req_ready, 0);
    do_req(26'h1FF);
    serve("queue line0", 32'h0000_1000);
    check("queue still full", bus_if.req_ready, 0);
    tick();
    check("queue ready after pop", bus_if.req_ready, 1);
    for (int i = 1; i < 5; i++) serve($sformatf("queue line%0d", i), 32'h0000_1000);
    repeat (3) tick();
    check("queue burst count", mem_q.size() - m0, 5);
    for (int i = 0; i < 5 && m0 + i < mem_q.size(); i++) begin
      check($sformatf("queue order %0d", i), mem_q[m0+i], {26'h100 + 26'(i), 6'b0});
    end
    check("queue done count", done_n - d0, 5);
    check("queue busy", bus_if.busy, 0);

    // coalesce: duplicate while queued, then again during the burst
    do_reset();
    mark();
    do_req(26'h10);
    do_req(26'h10);
    wait_mreq("coal");
    grant();
    send_beats(0, 16, 32'h0000_2000, -1, '0, 3, 26'h10);
    repeat (3) tick();
    check("coal count", bus_if.coalesce_count, 2);
    check("coal bursts", mem_q.size() - m0, 1);
    check("coal done", done_n - d0, 1);
    check("coal fills", fq_addr.size() - f0, 16);
    check("coal busy", bus_if.busy, 0);

    // snoop: queued 0x30 killed, in-flight 0x20 hit at beat 5
    do_reset();
    mark();
    do_req(26'h20);
    do_req(26'h30);
    do_inv(26'h30);
    wait_mreq("snoop");
    check("snoop mem_req_addr", bus_if.mem_req_addr, 32'h0000_0800);
    grant();
    send_beats(0, 16, 32'h0000_3000, 5, 26'h20, -1, '0);
    check("snoop last fill_drop", bus_if.fill_drop, 1);
    check("snoop last fill_done", bus_if.fill_done, 0);
    check("snoop last fill_we", bus_if.fill_we, 0);
    repeat (5) tick();
    check("snoop fill count", fq_addr.size() - f0, 6);
    if (fq_beat.size() > f0) check("snoop last beat", fq_beat[fq_beat.size()-1], 5);
    check("snoop done", done_n - d0, 0);
    check("snoop drop", drop_n - p0, 1);
    check("snoop bursts", mem_q.size() - m0, 1);
    check("snoop busy", bus_if.busy, 0);

    // same-cycle req and inv of a queued address
    do_reset();
    mark();
    do_req(26'h50);
    do_req(26'h40);
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 26'h40;
    bus_if.inv_valid = 1'b1;
    bus_if.inv_addr  = 26'h40;
    tick();
    bus_if.req_valid = 1'b0;
    bus_if.inv_valid = 1'b0;
    serve("same line50", 32'h0000_4000);
    serve("same line40", 32'h0000_5000);
    repeat (5) tick();
    check("same bursts", mem_q.size() - m0, 2);
    if (mem_q.size() >= m0 + 2) begin
      check("same first addr", mem_q[m0], 32'h0000_1400);
      check("same second addr", mem_q[m0+1], 32'h0000_1000);
    end
    check("same coalesce", bus_if.coalesce_count, 0);
    check("same done", done_n - d0, 2);
    check("same busy", bus_if.busy, 0);

    // reset at beat 8 abandons the burst
    do_reset();
    mark();
    do_req(26'h60);
    wait_mreq("rst");
    grant();
    send_beats(0, 8, 32'h0000_6000, -1, '0, -1, '0);
    bus_if.mem_rsp_valid = 1'b1;
    bus_if.mem_rsp_data  = 32'h0000_6020;
    reset = 1'b1;
    tick();
    check_idle_outputs("midrst");
    reset = 1'b0;
    send_beats(9, 7, 32'h0000_6000, -1, '0, -1, '0);
    repeat (3) tick();
    check("midrst fills", fq_addr.size() - f0, 8);
    check("midrst done", done_n - d0, 0);
    check("midrst drop", drop_n - p0, 0);
    check("midrst bursts", mem_q.size() - m0, 1);
    check("midrst busy", bus_if.busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
